// File: rtl/fft_scheduler_if.sv
// Handshake and address bundle between the FFT scheduler and its neighbours.
// Latency: none; this bundle only groups wires.
// Backpressure: in/bf/out valid-ready pairs; bf_wb is an unacknowledged pulse.
interface fft_scheduler_if #(
  parameter int LOG2_POINTS = 3
);
  // Sample load side
  logic                   in_valid;
  logic                   in_ready;
  logic                   wr_en;
  logic [LOG2_POINTS-1:0] wr_addr;

  // Butterfly unit side
  logic                   bf_valid;
  logic                   bf_ready;
  logic [LOG2_POINTS-1:0] bf_addr_a;
  logic [LOG2_POINTS-1:0] bf_addr_b;
  logic [LOG2_POINTS-2:0] bf_tw_idx;
  logic                   bf_wb;
  logic [LOG2_POINTS-1:0] stage;

  // Result unload side
  logic                   out_valid;
  logic                   out_ready;
  logic [LOG2_POINTS-1:0] out_addr;
  logic                   out_last;
  logic                   busy;

  // Scheduler side of the bundle
  modport master (
    input  in_valid, bf_ready, bf_wb, out_ready,
    output in_ready, wr_en, wr_addr,
    output bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, stage,
    output out_valid, out_addr, out_last, busy
  );

  // Source / butterfly / sink side of the bundle
  modport slave (
    output in_valid, bf_ready, bf_wb, out_ready,
    input  in_ready, wr_en, wr_addr,
    input  bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, stage,
    input  out_valid, out_addr, out_last, busy
  );
endinterface

// File: rtl/fft_scheduler.sv
// Sequences an in-place radix-2 DIT FFT: bit-reversed load, per-stage butterfly issue, natural-order unload.
// Latency: all outputs decode registered state; a stage takes N/2 issue cycles plus the writeback delay.
// Backpressure: in/bf/out handshakes stall their counters; a stage barrier waits for N/2 bf_wb pulses.
module fft_scheduler #(
  parameter int FFT_POINTS  = 8,
  parameter int LOG2_POINTS = 3
) (
  input  logic            clk,
  input  logic            rst,
  fft_scheduler_if.master sched
);

  localparam int AW           = LOG2_POINTS;
  localparam int OW           = LOG2_POINTS - 1;
  localparam int N_LAST_I     = FFT_POINTS - 1;
  localparam int HALF_I       = FFT_POINTS / 2;
  localparam int OP_LAST_I    = FFT_POINTS / 2 - 1;
  localparam int STAGE_LAST_I = LOG2_POINTS - 1;

  localparam logic [AW-1:0] N_LAST     = N_LAST_I[AW-1:0];
  localparam logic [AW-1:0] HALF       = HALF_I[AW-1:0];
  localparam logic [AW-1:0] STAGE_LAST = STAGE_LAST_I[AW-1:0];
  localparam logic [AW-1:0] ONE        = AW'(1);
  localparam logic [OW-1:0] OP_LAST    = OP_LAST_I[OW-1:0];

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] load_cnt_q, load_cnt_d;
  logic [OW-1:0] op_cnt_q, op_cnt_d;
  logic [AW-1:0] completed_q, completed_d;
  logic [AW-1:0] stage_q, stage_d;
  logic [AW-1:0] out_cnt_q, out_cnt_d;

  // Writeback bookkeeping, shared by ISSUE and WAIT
  logic          wb_hit;
  logic [AW-1:0] completed_inc;

  // Butterfly address decode intermediates
  logic [AW-1:0] op_ext;
  logic [AW-1:0] lo_mask;
  logic [AW-1:0] p_part;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] wr_addr_c;
  logic          in_ready_c;
  logic          issue_c;

  // State and counter registers; synchronous reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      load_cnt_q  <= '0;
      op_cnt_q    <= '0;
      completed_q <= '0;
      stage_q     <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      op_cnt_q    <= op_cnt_d;
      completed_q <= completed_d;
      stage_q     <= stage_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  // Next-state and counter updates for the load / issue / wait / unload sequence
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    op_cnt_d    = op_cnt_q;
    completed_d = completed_q;
    stage_d     = stage_q;
    out_cnt_d   = out_cnt_q;

    // Writebacks only mean something while a stage is in flight; the count
    // saturates so a stray extra pulse cannot wrap it back below the barrier.
    wb_hit        = sched.bf_wb && ((state_q == S_ISSUE) || (state_q == S_WAIT));
    completed_inc = (wb_hit && (completed_q != HALF)) ? completed_q + 1'b1 : completed_q;

    case (state_q)
      S_LOAD: begin
        if (sched.in_valid) begin
          if (load_cnt_q == N_LAST) begin
            load_cnt_d  = '0;
            op_cnt_d    = '0;
            completed_d = '0;
            stage_d     = '0;
            state_d     = S_ISSUE;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end

      S_ISSUE: begin
        completed_d = completed_inc;
        if (sched.bf_ready) begin
          op_cnt_d = op_cnt_q + 1'b1;
          if (op_cnt_q == OP_LAST) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Stage barrier: a writeback landing this cycle already counts.
        if (completed_inc == HALF) begin
          op_cnt_d    = '0;
          completed_d = '0;
          if (stage_q == STAGE_LAST) begin
            state_d = S_UNLOAD;
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else begin
          completed_d = completed_inc;
        end
      end

      S_UNLOAD: begin
        if (sched.out_ready) begin
          if (out_cnt_q == N_LAST) begin
            out_cnt_d = '0;
            state_d   = S_LOAD;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Output decode from registered state only (wr_en additionally follows in_valid)
  always_comb begin
    in_ready_c = (state_q == S_LOAD) && !rst;
    issue_c    = (state_q == S_ISSUE);

    // Bit-reverse the load counter so samples land in DIT input order.
    wr_addr_c = '0;
    for (int i = 0; i < AW; i++) begin
      wr_addr_c[i] = load_cnt_q[AW-1-i];
    end

    // For op j in stage s: p = j mod 2^s is the position inside the group,
    // and clearing those low bits then doubling gives the group base g*2^(s+1).
    op_ext  = {1'b0, op_cnt_q};
    lo_mask = (ONE << stage_q) - ONE;
    p_part  = op_ext & lo_mask;
    addr_a  = ((op_ext & ~lo_mask) << 1) | p_part;

    sched.in_ready  = in_ready_c;
    sched.wr_en     = sched.in_valid && in_ready_c;
    sched.wr_addr   = wr_addr_c;

    sched.bf_valid  = issue_c;
    sched.bf_addr_a = issue_c ? addr_a : '0;
    sched.bf_addr_b = issue_c ? (addr_a + lo_mask + ONE) : '0;
    // p < 2^s, so its top bit is always clear and the shift stays in range.
    sched.bf_tw_idx = issue_c ? (p_part[OW-1:0] << (STAGE_LAST - stage_q)) : '0;
    sched.stage     = stage_q;

    sched.out_valid = (state_q == S_UNLOAD);
    sched.out_addr  = out_cnt_q;
    sched.out_last  = (state_q == S_UNLOAD) && (out_cnt_q == N_LAST);
    sched.busy      = (state_q != S_LOAD);
  end

endmodule

// File: tb/tb_fft_scheduler.sv
// Self-checking bench for fft_scheduler: directed frames plus randomized stalls against a reference op list.
// Latency: checks stage barrier timing (first op one cycle after the stage's last writeback).
// Backpressure: randomizes bf_ready/out_ready/in_valid gaps and withholds one writeback.
module tb_fft_scheduler;

  localparam int N     = 8;
  localparam int L     = 3;
  localparam int HALF  = N / 2;
  localparam int TOTAL = HALF * L;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_scheduler_if #(.LOG2_POINTS(L)) bus ();

  fft_scheduler #(
    .FFT_POINTS (N),
    .LOG2_POINTS(L)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sched(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference op list: every butterfly of every stage, in issue order
  int exp_a[$];
  int exp_b[$];
  int exp_tw[$];
  int exp_st[$];

  int first_op[L];
  int last_wb[L];
  int first_out;
  bit ab;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < L; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // Textbook DIT loop nest: groups of span 2h, butterfly (k+p, k+p+h), twiddle p*N/(2h)
  task automatic build_model();
    for (int s = 0; s < L; s++) begin
      int h;
      h = 1 << s;
      for (int k = 0; k < N; k += 2 * h) begin
        for (int p = 0; p < h; p++) begin
          exp_a.push_back(k + p);
          exp_b.push_back(k + p + h);
          exp_tw.push_back(p * (N / (2 * h)));
          exp_st.push_back(s);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  0);
    check({tag, "_wr_en"},     bus.wr_en,     0);
    check({tag, "_bf_valid"},  bus.bf_valid,  0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"},  bus.out_last,  0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_wr_addr"},   bus.wr_addr,   0);
    check({tag, "_addr_a"},    bus.bf_addr_a, 0);
    check({tag, "_addr_b"},    bus.bf_addr_b, 0);
    check({tag, "_tw"},        bus.bf_tw_idx, 0);
    check({tag, "_stage"},     bus.stage,     0);
    check({tag, "_out_addr"},  bus.out_addr,  0);
  endtask

  task automatic load_frame(input bit gaps, input bit spurious);
    int i = 0;
    int t = 0;
    while (i < N && t < 200) begin
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.bf_wb    = spurious ? ($urandom_range(0, 1) == 1) : 1'b0;
      #1;
      check("load_in_ready", bus.in_ready, 1);
      check("load_bf_valid", bus.bf_valid, 0);
      check("load_wr_addr",  bus.wr_addr,  bitrev(i));
      check("load_wr_en",    bus.wr_en,    bus.in_valid);
      if (bus.in_valid) i++;
      step();
      t++;
    end
    check("load_count", i, N);
    bus.in_valid = 1'b0;
    bus.bf_wb    = 1'b0;
    #1;
    check("load_in_ready_drop", bus.in_ready, 0);
    check("load_bf_valid_rise", bus.bf_valid, 1);
  endtask

  task automatic run_stages(input int d, input bit rnd_ready, input int hold_stage,
                            input int abort_stage, output bit aborted);
    int wbq[$];
    int wbs[$];
    int idx  = 0;
    int idle = 0;
    int t    = 0;
    int s;
    int ws;
    bit holding;
    bit done = 1'b0;
    holding = (hold_stage >= 0);
    aborted = 1'b0;
    for (int k = 0; k < L; k++) begin
      first_op[k] = -1;
      last_wb[k]  = -1;
    end
    first_out = -1;
    while (!done && t < 3000) begin
      bus.bf_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.bf_wb    = 1'b0;
      if (wbq.size() > 0 && wbq[0] == cyc) begin
        void'(wbq.pop_front());
        ws = wbs.pop_front();
        last_wb[ws] = cyc;
        bus.bf_wb = 1'b1;
      end
      if (holding && idx == (hold_stage + 1) * HALF && wbq.size() == 0 && !bus.bf_valid) begin
        check("hold_stage", bus.stage, hold_stage);
        check("hold_busy",  bus.busy,  1);
        check("hold_out_valid", bus.out_valid, 0);
        idle++;
        if (idle == 20) begin
          bus.bf_wb = 1'b1;
          last_wb[hold_stage] = cyc;
          holding = 1'b0;
        end
      end
      #1;
      if (bus.out_valid) begin
        first_out = cyc;
        done = 1'b1;
      end else if (bus.bf_valid) begin
        if (idx >= TOTAL) begin
          check("extra_op", idx, TOTAL - 1);
          done = 1'b1;
        end else begin
          s = exp_st[idx];
          check("op_addr_a", bus.bf_addr_a, exp_a[idx]);
          check("op_addr_b", bus.bf_addr_b, exp_b[idx]);
          check("op_tw_idx", bus.bf_tw_idx, exp_tw[idx]);
          check("op_stage",  bus.stage,     s);
          if (idx % HALF == 0 && first_op[s] < 0) begin
            first_op[s] = cyc;
            if (s > 0) check("stage_barrier", cyc, last_wb[s-1] + 1);
          end
          if (abort_stage == s && idx % HALF == 1) begin
            aborted = 1'b1;
            done = 1'b1;
          end else if (bus.bf_ready) begin
            if (!(holding && idx == (hold_stage + 1) * HALF - 1)) begin
              wbq.push_back(cyc + d);
              wbs.push_back(s);
            end
            idx++;
          end
        end
      end else begin
        check("wait_busy", bus.busy, 1);
        check("wait_in_ready", bus.in_ready, 0);
        if (idx > 0) check("wait_stage", bus.stage, exp_st[idx-1]);
      end
      if (!done) begin
        step();
        t++;
      end
    end
    check("stages_done", done, 1);
    if (!aborted) begin
      check("ops_issued", idx, TOTAL);
      check("unload_start", first_out, last_wb[L-1] + 1);
    end
  endtask

  task automatic unload_frame(input bit toggle);
    int a = 0;
    int t = 0;
    bit r = 1'b1;
    while (a < N && t < 200) begin
      bus.out_ready = toggle ? r : ($urandom_range(0, 1) == 1);
      r = ~r;
      bus.bf_wb = ($urandom_range(0, 3) == 0);
      #1;
      check("unl_out_valid", bus.out_valid, 1);
      check("unl_out_addr",  bus.out_addr,  a);
      check("unl_out_last",  bus.out_last,  (a == N - 1));
      check("unl_busy",      bus.busy,      1);
      check("unl_bf_valid",  bus.bf_valid,  0);
      if (bus.out_ready) a++;
      step();
      t++;
    end
    check("unload_count", a, N);
    bus.out_ready = 1'b0;
    bus.bf_wb     = 1'b0;
    #1;
    check("b2b_in_ready",  bus.in_ready,  1);
    check("b2b_out_valid", bus.out_valid, 0);
    check("b2b_busy",      bus.busy,      0);
  endtask

  task automatic check_stage_spacing(input string tag);
    check({tag, "_s1_gap"}, first_op[1] - first_op[0], 6);
    check({tag, "_s2_gap"}, first_op[2] - first_op[1], 6);
    check({tag, "_to_out"}, first_out - first_op[0], 18);
  endtask

  initial begin
    build_model();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.bf_ready  = 1'b0;
    bus.bf_wb     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    #1;
    check_reset_vals("rst");

    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_busy",     bus.busy,     0);

    // Directed frame: full-rate load with stray writebacks, D=2, toggled unload
    load_frame(1'b0, 1'b1);
    run_stages(2, 1'b0, -1, -1, ab);
    check_stage_spacing("dir");
    unload_frame(1'b1);

    // Random bf_ready stalls with the last stage-1 writeback withheld for a while
    load_frame(1'b1, 1'b0);
    run_stages(2, 1'b1, 1, -1, ab);
    unload_frame(1'b0);

    // Random frames with varied writeback delay
    for (int f = 0; f < 4; f++) begin
      load_frame(1'b1, 1'b1);
      run_stages($urandom_range(1, 4), 1'b1, -1, -1, ab);
      unload_frame(1'b0);
    end

    // Abort in the middle of stage 1, then a clean frame from scratch
    load_frame(1'b0, 1'b0);
    run_stages(2, 1'b0, -1, 1, ab);
    check("abort_reached", ab, 1);
    rst          = 1'b1;
    bus.bf_wb    = 1'b0;
    bus.bf_ready = 1'b0;
    bus.in_valid = 1'b1;
    step();
    #1;
    check_reset_vals("mid_rst");
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("re_rst_in_ready", bus.in_ready, 1);

    load_frame(1'b0, 1'b0);
    run_stages(2, 1'b0, -1, -1, ab);
    check_stage_spacing("rerun");
    unload_frame(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
